pipe_ctrl_unit: RTL and testbench

//  Parametrised pipeline stall/flush controller for the MIPS core, successor to the fixed 6-stage controller.

---
 rtl/pipe_ctrl_unit_pkg.sv | 20 ++
 rtl/pipe_ctrl_unit_if.sv | 27 ++
 rtl/pipe_ctrl_unit_stall_prefix_enc.sv | 17 +
 rtl/pipe_ctrl_unit.sv | 124 ++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared constants and types for the pipeline stall/flush controller.
// Exception codes match the mem-stage excepttype encoding.
package pipe_ctrl_unit_pkg;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
   localparam logic [31:0] EXC_INT   = 32'h0000_0001;
   localparam logic [31:0] EXC_SYS   = 32'h0000_0008;
   localparam logic [31:0] EXC_RI    = 32'h0000_000A;
   localparam logic [31:0] EXC_TR    = 32'h0000_000D;
   localparam logic [31:0] EXC_ERET  = 32'h0000_000E;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_FLUSH = 1'b1
   } state_t;

endpackage

// File: rtl/pipe_ctrl_unit_if.sv
// Datapath <-> controller bundle: stall requests and exception info in, stall/flush/redirect out.
// The datapath holds the master modport, the controller the slave modport.
interface pipe_ctrl_unit_if #(
   parameter int NSTAGE = 6,
   parameter int ADDR_W = 32
);
   logic [NSTAGE-1:0] stallreq;
   logic [31:0]       excepttype;
   logic [ADDR_W-1:0] cp0_epc;
   logic              wdog_clr;
   logic [NSTAGE-1:0] stall;
   logic              flush;
   logic [ADDR_W-1:0] new_pc;
   logic              redirect;
   logic [31:0]       stall_cnt;
   logic              wdog;

   modport master (
      output stallreq, excepttype, cp0_epc, wdog_clr,
      input  stall, flush, new_pc, redirect, stall_cnt, wdog
   );

   modport slave (
      input  stallreq, excepttype, cp0_epc, wdog_clr,
      output stall, flush, new_pc, redirect, stall_cnt, wdog
   );
endinterface

// File: rtl/pipe_ctrl_unit_stall_prefix_enc.sv
// Priority-to-thermometer encoder: every bit at or below the highest set request is set.
// Purely combinational, zero latency.
module stall_prefix_enc #(
   parameter int N = 6
) (
   input  logic [N-1:0] req,
   output logic [N-1:0] therm
);
   always_comb begin
      logic acc;
      acc = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         acc      = acc | req[i];
         therm[i] = acc;
      end
   end
endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline stall/flush controller: merges stall requests, resolves exception redirects, counts stalls.
// Exception flush/redirect and stall merge are combinational (0 latency); flush persists FLUSH_CYC cycles.
module pipe_ctrl_unit
   import pipe_ctrl_unit_pkg::*;
#(
   parameter int                NSTAGE    = 6,
   parameter int                ADDR_W    = 32,
   parameter int                FLUSH_CYC = 1,
   parameter logic [ADDR_W-1:0] INT_VEC   = 'h20,
   parameter logic [ADDR_W-1:0] EXC_VEC   = 'h40,
   parameter int                WDOG_W    = 16,
   parameter logic [WDOG_W-1:0] WDOG_LIM  = '1
) (
   input logic            clk,
   input logic            rst,
   pipe_ctrl_unit_if.slave bus
);
   localparam int FC_W = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC) : 1;
   // The wb stage never requests a stall; its request bit is masked off.
   localparam logic [NSTAGE-1:0] REQ_MASK = {1'b0, {(NSTAGE-1){1'b1}}};

   state_t            state, state_nxt;
   logic [FC_W-1:0]   fcnt, fcnt_nxt;
   logic [ADDR_W-1:0] pc_hold, pc_hold_nxt;
   logic [ADDR_W-1:0] exc_pc;
   logic [NSTAGE-1:0] therm;
   logic [NSTAGE-1:0] stall_c;
   logic              flush_c, redir_c;
   logic [ADDR_W-1:0] new_pc_c;
   logic              stall_any;
   logic [31:0]       stall_cnt_q;
   logic [WDOG_W-1:0] wcnt;
   logic              wdog_q;

   stall_prefix_enc #(.N(NSTAGE)) u_enc (
      .req   (bus.stallreq & REQ_MASK),
      .therm (therm)
   );

   always_comb begin
      case (bus.excepttype)
         EXC_INT:                  exc_pc = INT_VEC;
         EXC_SYS, EXC_RI, EXC_TR:  exc_pc = EXC_VEC;
         EXC_ERET:                 exc_pc = bus.cp0_epc;
         default:                  exc_pc = EXC_VEC;
      endcase
   end

   always_comb begin
      state_nxt   = state;
      fcnt_nxt    = fcnt;
      pc_hold_nxt = pc_hold;
      stall_c     = {NSTAGE{NO_STOP}};
      flush_c     = NO_STOP;
      redir_c     = 1'b0;
      new_pc_c    = '0;
      case (state)
         S_IDLE: begin
            if (bus.excepttype != ZERO_WORD) begin
               flush_c  = STOP;
               redir_c  = 1'b1;
               new_pc_c = exc_pc;
               if (FLUSH_CYC > 1) begin
                  state_nxt   = S_FLUSH;
                  fcnt_nxt    = FC_W'(FLUSH_CYC - 2);
                  pc_hold_nxt = exc_pc;
               end
            end else begin
               stall_c = therm;
            end
         end
         S_FLUSH: begin
            flush_c  = STOP;
            new_pc_c = pc_hold;
            if (fcnt == '0) state_nxt = S_IDLE;
            else            fcnt_nxt  = fcnt - FC_W'(1);
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign stall_any = |stall_c;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         fcnt    <= '0;
         pc_hold <= '0;
      end else begin
         state   <= state_nxt;
         fcnt    <= fcnt_nxt;
         pc_hold <= pc_hold_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                       stall_cnt_q <= '0;
      else if (stall_any && (stall_cnt_q != '1))      stall_cnt_q <= stall_cnt_q + 32'd1;
   end

   // Clear beats trip; wcnt parks at the limit so it cannot wrap during a long lock-up.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wcnt   <= '0;
         wdog_q <= 1'b0;
      end else if (bus.wdog_clr) begin
         wcnt   <= '0;
         wdog_q <= 1'b0;
      end else if (stall_any && !flush_c) begin
         if (wcnt != WDOG_LIM)                 wcnt   <= wcnt + WDOG_W'(1);
         if (wcnt >= WDOG_LIM - WDOG_W'(1))    wdog_q <= 1'b1;
      end else begin
         wcnt <= '0;
      end
   end

   assign bus.stall     = rst ? stall_c     : '0;
   assign bus.flush     = rst ? flush_c     : 1'b0;
   assign bus.redirect  = rst ? redir_c     : 1'b0;
   assign bus.new_pc    = rst ? new_pc_c    : '0;
   assign bus.stall_cnt = rst ? stall_cnt_q : '0;
   assign bus.wdog      = rst ? wdog_q      : 1'b0;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed and random stimulus for pipe_ctrl_unit, checked against a cycle-level reference model.
module tb_pipe_ctrl_unit;
   localparam int          NS  = 6;
   localparam int          FC  = 3;
   localparam int          LIM = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pipe_ctrl_unit_if #(.NSTAGE(NS), .ADDR_W(32)) bus ();

   pipe_ctrl_unit #(
      .NSTAGE(NS), .ADDR_W(32), .FLUSH_CYC(FC),
      .INT_VEC(32'h20), .EXC_VEC(32'h40),
      .WDOG_W(16), .WDOG_LIM(16'(LIM))
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int          m_left;
   logic [31:0] m_pc;
   logic [31:0] m_cnt;
   int          m_run;
   bit          m_wd;
   logic [NS-1:0] exp_stall;
   logic          exp_flush, exp_redir;
   logic [31:0]   exp_pc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] pc_of(input logic [31:0] code, input logic [31:0] epc);
      if (code == 32'h1) return 32'h20;
      if (code == 32'hE) return epc;
      return 32'h40;
   endfunction

   function automatic logic [NS-1:0] prefix_of(input logic [NS-1:0] req);
      int k = -1;
      for (int i = 0; i < NS - 1; i++) if (req[i]) k = i;
      if (k < 0) return '0;
      return NS'((1 << (k + 1)) - 1);
   endfunction

   task automatic model_reset();
      m_left = 0; m_pc = '0; m_cnt = '0; m_run = 0; m_wd = 0;
      exp_stall = '0; exp_flush = 0; exp_redir = 0; exp_pc = '0;
   endtask

   task automatic model_expect();
      exp_stall = '0; exp_flush = 0; exp_redir = 0; exp_pc = '0;
      if (m_left > 0) begin
         exp_flush = 1; exp_pc = m_pc;
      end else if (bus.excepttype != 0) begin
         exp_flush = 1; exp_redir = 1; exp_pc = pc_of(bus.excepttype, bus.cp0_epc);
      end else begin
         exp_stall = prefix_of(bus.stallreq);
      end
   endtask

   task automatic model_clock();
      if (exp_stall != 0 && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (bus.wdog_clr) begin
         m_run = 0; m_wd = 0;
      end else if (exp_stall != 0) begin
         if (m_run < LIM) m_run++;
         if (m_run >= LIM) m_wd = 1;
      end else begin
         m_run = 0;
      end
      if (m_left > 0) m_left--;
      else if (bus.excepttype != 0) begin
         m_left = FC - 1;
         m_pc   = pc_of(bus.excepttype, bus.cp0_epc);
      end
   endtask

   task automatic step(input logic [NS-1:0] req, input logic [31:0] exc,
                       input logic [31:0] epc, input logic clr);
      @(posedge clk);
      model_clock();
      @(negedge clk);
      bus.stallreq = req; bus.excepttype = exc; bus.cp0_epc = epc; bus.wdog_clr = clr;
      #1;
      model_expect();
      chk("stall",     64'(bus.stall),     64'(exp_stall));
      chk("flush",     64'(bus.flush),     64'(exp_flush));
      chk("redirect",  64'(bus.redirect),  64'(exp_redir));
      chk("new_pc",    64'(bus.new_pc),    64'(exp_pc));
      chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_cnt));
      chk("wdog",      64'(bus.wdog),      64'(m_wd));
   endtask

   // Asserted mid-cycle: outputs must drop at once, without waiting for a clock edge.
   task automatic do_reset();
      #2;
      rst = 1'b0;
      #1;
      chk("rst_stall",     64'(bus.stall),     64'h0);
      chk("rst_flush",     64'(bus.flush),     64'h0);
      chk("rst_redirect",  64'(bus.redirect),  64'h0);
      chk("rst_new_pc",    64'(bus.new_pc),    64'h0);
      chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'h0);
      chk("rst_wdog",      64'(bus.wdog),      64'h0);
      bus.stallreq = '0; bus.excepttype = '0; bus.cp0_epc = '0; bus.wdog_clr = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      logic [NS-1:0] req;
      logic [31:0]   exc;
      int            r;
      bus.stallreq = '0; bus.excepttype = '0; bus.cp0_epc = '0; bus.wdog_clr = 1'b0;
      model_reset();
      #3;
      chk("init_flush", 64'(bus.flush), 64'h0);
      chk("init_stall", 64'(bus.stall), 64'h0);
      @(negedge clk);
      rst = 1'b1;

      // highest requester sets the prefix; stall count climbs once per stalled cycle
      for (int i = 0; i < 3; i++) begin
         step(6'b010000, 0, 0, 0);
         chk("t1_stall", 64'(bus.stall), 64'h1F);
         chk("t1_cnt",   64'(bus.stall_cnt), 64'(i));
      end
      step(6'b000000, 0, 0, 0);
      step(6'b001100, 0, 0, 0);
      chk("t2_stall", 64'(bus.stall), 64'h0F);
      step(6'b100000, 0, 0, 0);
      chk("wb_ignored", 64'(bus.stall), 64'h0);

      // exception beats a simultaneous stall request
      step(6'b001000, 32'h1, 0, 0);
      chk("t3_flush", 64'(bus.flush), 64'h1);
      chk("t3_redir", 64'(bus.redirect), 64'h1);
      chk("t3_pc",    64'(bus.new_pc), 64'h20);
      chk("t3_stall", 64'(bus.stall), 64'h0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("t3_done", 64'(bus.flush), 64'h0);

      // ERET target latched; a second code during the flush window is ignored
      step(0, 32'hE, 32'h100, 0);
      chk("t4_pc0", 64'(bus.new_pc), 64'h100);
      step(0, 32'h8, 32'h200, 0);
      chk("t4_pc1",    64'(bus.new_pc), 64'h100);
      chk("t4_redir1", 64'(bus.redirect), 64'h0);
      step(0, 0, 0, 0);
      chk("t4_flush2", 64'(bus.flush), 64'h1);
      step(0, 0, 0, 0);
      chk("t4_end", 64'(bus.flush), 64'h0);

      // watchdog trips after the 4th stalled cycle, stays sticky, clears on request
      for (int i = 0; i < 4; i++) begin
         step(6'b000010, 0, 0, 0);
         chk("t5_pre", 64'(bus.wdog), 64'h0);
      end
      step(6'b000010, 0, 0, 0);
      chk("t5_trip", 64'(bus.wdog), 64'h1);
      step(0, 0, 0, 0);
      chk("t5_sticky", 64'(bus.wdog), 64'h1);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      chk("t5_clr", 64'(bus.wdog), 64'h0);

      // reset in the middle of a flush window
      step(0, 32'hA, 0, 0);
      step(0, 0, 0, 0);
      chk("t6_inflush", 64'(bus.flush), 64'h1);
      do_reset();
      step(0, 0, 0, 0);
      chk("t6_idle", 64'(bus.flush), 64'h0);

      // random traffic
      req = '0;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 1) == 0) req = NS'($urandom_range(0, 63));
         r = $urandom_range(0, 39);
         case (r)
            0: exc = 32'h1;
            1: exc = 32'h8;
            2: exc = 32'hA;
            3: exc = 32'hD;
            4: exc = 32'hE;
            5: exc = $urandom;
            default: exc = 32'h0;
         endcase
         step(req, exc, $urandom, ($urandom_range(0, 15) == 0));
         if ($urandom_range(0, 99) == 0) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1);
   end
endmodule
